// File: rtl/ibex_register_file_sequencer.sv
// Saves (dump) or reloads (restore) x1..xLAST through the register-file ports once the core is halted.
// Dump beats leave on a valid/ready stream; restore beats arrive on one and are written straight through.
module ibex_register_file_sequencer #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 stall_req_o,
    input  logic                 core_idle_i,
    output logic [4:0]           rf_raddr_o,
    input  logic [DataWidth-1:0] rf_rdata_i,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_we_o,
    output logic                 dump_valid_o,
    input  logic                 dump_ready_i,
    output logic [4:0]           dump_addr_o,
    output logic [DataWidth-1:0] dump_data_o,
    input  logic                 rest_valid_i,
    output logic                 rest_ready_o,
    input  logic [DataWidth-1:0] rest_data_i,
    output logic [2:0]           state_o
);

    // Handshakes: a beat transfers on the rising clock edge where valid and ready are both high.
    // A dump beat, once valid, holds addr/data unchanged until accepted (or the operation is aborted).
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_IDLE = 3'd1,
        S_DUMP      = 3'd2,
        S_RESTORE   = 3'd3,
        S_DONE      = 3'd4
    } state_e;

    localparam logic [4:0] LastIdx = RV32E ? 5'd15 : 5'd31;

    state_e               state_q;
    logic                 mode_q;
    logic [4:0]           idx_q;
    logic                 loaded_all_q;
    logic                 dump_valid_q;
    logic [4:0]           dump_addr_q;
    logic [DataWidth-1:0] dump_data_q;

    logic rest_fire;
    logic dump_load;
    logic dump_fire;

    assign rest_ready_o = (state_q == S_RESTORE) && core_idle_i && !abort_i;
    assign rest_fire    = rest_valid_i && rest_ready_o;

    // Output register refills whenever it is empty or its beat is leaving this cycle.
    assign dump_load = (state_q == S_DUMP) && core_idle_i && !abort_i && !loaded_all_q &&
                       (!dump_valid_q || dump_ready_i);
    assign dump_fire = dump_valid_q && dump_ready_i;

    assign busy_o       = (state_q != S_IDLE);
    assign stall_req_o  = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE) && !abort_i;
    assign rf_raddr_o   = (state_q == S_DUMP) ? idx_q : 5'd0;
    assign rf_we_o      = rest_fire;
    assign rf_waddr_o   = rest_fire ? idx_q : 5'd0;
    assign rf_wdata_o   = rest_fire ? rest_data_i : '0;
    assign dump_valid_o = dump_valid_q;
    assign dump_addr_o  = dump_addr_q;
    assign dump_data_o  = dump_data_q;
    assign state_o      = state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            idx_q        <= 5'd1;
            loaded_all_q <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= 5'd0;
            dump_data_q  <= '0;
        end else if (abort_i && (state_q != S_IDLE)) begin
            state_q      <= S_IDLE;
            idx_q        <= 5'd1;
            loaded_all_q <= 1'b0;
            dump_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q      <= S_WAIT_IDLE;
                        mode_q       <= mode_i;
                        idx_q        <= 5'd1;
                        loaded_all_q <= 1'b0;
                    end
                end
                S_WAIT_IDLE: begin
                    if (core_idle_i) begin
                        state_q <= mode_q ? S_RESTORE : S_DUMP;
                    end
                end
                S_DUMP: begin
                    if (dump_load) begin
                        dump_valid_q <= 1'b1;
                        dump_addr_q  <= idx_q;
                        dump_data_q  <= rf_rdata_i;
                        if (idx_q == LastIdx) begin
                            loaded_all_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end else if (dump_fire) begin
                        dump_valid_q <= 1'b0;
                    end
                    if (dump_fire && (dump_addr_q == LastIdx)) begin
                        state_q <= S_DONE;
                    end
                end
                S_RESTORE: begin
                    if (rest_fire) begin
                        if (idx_q == LastIdx) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
